// File: rtl/mem_access_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_pkg : shared types and encodings for the data-memory access unit
// Revision 1.0
// ---------------------------------------------------------------------------
package mem_access_pkg;

   localparam logic [2:0] TYPE_B  = 3'b000;
   localparam logic [2:0] TYPE_H  = 3'b001;
   localparam logic [2:0] TYPE_W  = 3'b010;
   localparam logic [2:0] TYPE_BU = 3'b100;
   localparam logic [2:0] TYPE_HU = 3'b101;

   localparam logic [2:0] SZ_B = 3'd1;
   localparam logic [2:0] SZ_H = 3'd2;
   localparam logic [2:0] SZ_W = 3'd4;

   localparam int ENTRY_AW = 32;
   localparam int ENTRY_DW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      RSP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [ENTRY_AW-1:0] addr;
      logic [ENTRY_DW-1:0] wdata;
      logic [2:0]          size;
   } store_entry_t;

   function automatic logic [2:0] type_size(input logic [2:0] t);
      case (t[1:0])
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_access_unit_store_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_buffer : in-order FIFO of posted stores, head visible combinationally
// Revision 1.0
// ---------------------------------------------------------------------------
module store_buffer #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 67
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; the occupancy count alone defines validity.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule
`default_nettype wire

// File: rtl/data_mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_access_unit : load/store front end with posted store buffer
// Revision 1.0
// ---------------------------------------------------------------------------
module data_mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_type,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [2:0]    mem_type,
   output logic          mem_rd_en,
   output logic          mem_wr_en,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_stall
);

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_addr;
   logic [2:0]    r_type;
   logic [DW-1:0] r_rdata;
   logic          r_err;

   logic          w_illegal;
   logic          w_misaligned;
   logic          w_err;
   logic          w_ready;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_drain;
   store_entry_t  w_din;
   store_entry_t  w_head;

   function automatic logic [DW-1:0] extend(input logic [DW-1:0] d, input logic [2:0] t);
      case (t)
         TYPE_B:  return {{(DW-8){d[7]}}, d[7:0]};
         TYPE_H:  return {{(DW-16){d[15]}}, d[15:0]};
         TYPE_BU: return {{(DW-8){1'b0}}, d[7:0]};
         TYPE_HU: return {{(DW-16){1'b0}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   always_comb begin
      w_illegal = 1'b0;
      case (req_type)
         TYPE_B, TYPE_H, TYPE_W: w_illegal = 1'b0;
         TYPE_BU, TYPE_HU:       w_illegal = req_we;
         default:                w_illegal = 1'b1;
      endcase
   end

   assign w_misaligned = ((req_type == TYPE_H || req_type == TYPE_HU) && req_addr[0]) ||
                         ((req_type == TYPE_W) && (req_addr[1:0] != 2'b00));
   assign w_err = w_illegal || w_misaligned;

   // Loads wait for an empty buffer so they always see every earlier store.
   always_comb begin
      w_ready = 1'b0;
      if (r_state == IDLE) begin
         if (w_err)       w_ready = 1'b1;
         else if (req_we) w_ready = !w_full;
         else             w_ready = w_empty;
      end
   end

   assign req_ready = w_ready && Reset;
   assign w_accept  = req_valid && req_ready;
   assign w_push    = w_accept && req_we && !w_err;
   assign w_drain   = (r_state != RD) && !w_empty;
   assign w_pop     = w_drain && !mem_stall;

   always_comb begin
      w_din       = '0;
      w_din.addr  = ENTRY_AW'(req_addr);
      w_din.wdata = ENTRY_DW'(req_wdata);
      w_din.size  = type_size(req_type);
   end

   store_buffer #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(store_entry_t))
   ) u_store_buffer (
      .CLK     (CLK),
      .Reset   (Reset),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_next = (w_err || req_we) ? RSP : RD;
         RD:   if (!mem_stall) w_next = RSP;
         RSP:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_addr  <= '0;
         r_type  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (r_state == IDLE && w_accept) begin
         r_addr  <= req_addr;
         r_type  <= req_type;
         r_rdata <= '0;
         r_err   <= w_err;
      end else if (r_state == RD && !mem_stall) begin
         r_rdata <= extend(mem_rdata, r_type);
      end
   end

   // A read in flight owns the memory port; drain resumes once it is done.
   always_comb begin
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_type  = '0;
      if (r_state == RD) begin
         mem_rd_en = 1'b1;
         mem_addr  = r_addr;
         mem_type  = type_size(r_type);
      end else if (w_drain) begin
         mem_wr_en = 1'b1;
         mem_addr  = w_head.addr[AW-1:0];
         mem_wdata = w_head.wdata[DW-1:0];
         mem_type  = w_head.size;
      end
   end

   assign rsp_valid = (r_state == RSP);
   assign rsp_rdata = rsp_valid ? r_rdata : '0;
   assign rsp_err   = rsp_valid && r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_mem_access_unit : directed bench with a transaction-level reference
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_data_mem_access_unit;

   localparam int DEPTH = 2;
   localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010;
   localparam logic [2:0] T_BU = 3'b100, T_HU = 3'b101, T_BAD = 3'b011;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_type = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_type;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [31:0] mem_rdata;
   logic        mem_stall = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] phys [0:4095];

   always #5 CLK = ~CLK;

   data_mem_access_unit #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .CLK(CLK), .Reset(Reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_type(mem_type),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_rdata(mem_rdata), .mem_stall(mem_stall)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int m_size(input logic [2:0] t);
      if (t == T_H || t == T_HU) return 2;
      if (t == T_W) return 4;
      return 1;
   endfunction

   function automatic logic m_err(input logic we, input logic [2:0] t, input logic [31:0] a);
      logic legal;
      legal = (t == T_B || t == T_H || t == T_W) || ((t == T_BU || t == T_HU) && !we);
      return !legal || ((a % m_size(t)) != 0);
   endfunction

   function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [2:0] t);
      if (t == T_B) return (w >= 32'h80) ? w - 32'h100 : w;
      if (t == T_H) return (w >= 32'h8000) ? w - 32'h10000 : w;
      return w;
   endfunction

   function automatic logic [31:0] rdsz(input logic [31:0] a, input int sz);
      logic [31:0] w;
      w = 0;
      for (int i = 0; i < sz; i++) w = w + (32'(phys[12'(a + i)]) << (8 * i));
      return w;
   endfunction

   // Memory returns the addressed bytes right-justified while a read is asserted.
   always @(*) mem_rdata = mem_rd_en ? rdsz(mem_addr, int'(mem_type)) : 32'h0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          s;
   } ent_t;

   ent_t        q[$];
   int          ph = 0;            // 0 idle, 1 resp due, 2 reading, 3 load resp due
   logic [31:0] exp_rd = 0;
   logic        exp_err = 0;
   logic [31:0] ld_addr = 0;
   logic [2:0]  ld_t = 0;
   int          cyc = 0;
   int          n_rd = 0;
   int          n_wr = 0;
   int          cm_cyc[$];
   logic [31:0] cm_addr[$];

   always @(negedge CLK) begin
      int   nph;
      logic rdy_exp;
      ent_t e;
      cyc++;
      if (!Reset) begin
         q.delete();
         ph = 0;
         chk("rst_ready", {31'b0, req_ready}, 0);
         chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
         chk("rst_enables", {30'b0, mem_rd_en, mem_wr_en}, 0);
         chk("rst_mem_addr", mem_addr, 0);
      end else begin
         rdy_exp = (ph == 0) && (m_err(req_we, req_type, req_addr) ? 1'b1 :
                   req_we ? (q.size() < DEPTH) : (q.size() == 0));
         chk("req_ready", {31'b0, req_ready}, {31'b0, rdy_exp});
         chk("rd_wr_exclusive", {31'b0, mem_rd_en & mem_wr_en}, 0);
         if (mem_rd_en) n_rd++;
         if (mem_wr_en) n_wr++;
         if (!mem_rd_en && !mem_wr_en)
            chk("idle_mem_bus", mem_addr | mem_wdata | {29'b0, mem_type}, 0);
         chk("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, (q.size() != 0) && (ph != 2)});
         if (mem_wr_en && q.size() != 0) begin
            e = q[0];
            chk("wr_addr", mem_addr, e.a);
            chk("wr_data", mem_wdata, e.d);
            chk("wr_size", {29'b0, mem_type}, e.s);
            if (!mem_stall) begin
               for (int i = 0; i < e.s; i++) phys[12'(e.a + i)] = 8'(e.d >> (8 * i));
               cm_cyc.push_back(cyc);
               cm_addr.push_back(e.a);
               void'(q.pop_front());
            end
         end
         nph = ph;
         if (ph == 1 || ph == 3) begin
            chk("rsp_valid", {31'b0, rsp_valid}, 1);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
            chk("rsp_rdata", rsp_rdata, exp_rd);
            nph = 0;
         end else begin
            chk("rsp_valid_idle", {31'b0, rsp_valid}, 0);
            if (ph == 2) begin
               chk("rd_en", {31'b0, mem_rd_en}, 1);
               chk("rd_addr", mem_addr, ld_addr);
               chk("rd_size", {29'b0, mem_type}, m_size(ld_t));
               if (!mem_stall) begin
                  exp_rd  = m_ext(rdsz(ld_addr, m_size(ld_t)), ld_t);
                  exp_err = 1'b0;
                  nph     = 3;
               end
            end else begin
               chk("rd_en_idle", {31'b0, mem_rd_en}, 0);
            end
         end
         if (req_valid && req_ready) begin
            if (m_err(req_we, req_type, req_addr)) begin
               exp_err = 1'b1; exp_rd = 0; nph = 1;
            end else if (req_we) begin
               q.push_back('{a: req_addr, d: req_wdata, s: m_size(req_type)});
               exp_err = 1'b0; exp_rd = 0; nph = 1;
            end else begin
               ld_addr = req_addr; ld_t = req_type; nph = 2;
            end
         end
         ph = nph;
      end
   end

   task automatic do_req(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input int stall_n,
                         output logic [31:0] rd, output logic err,
                         output int wait_c, output int lat);
      rd = 0; err = 0; lat = 0;
      @(posedge CLK); #1;
      req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = d;
      #1;
      wait_c = 0;
      while (!req_ready && wait_c < 200) begin
         @(posedge CLK); #2;
         wait_c++;
      end
      if (!req_ready) begin
         n_checks++; n_fail++;
         $display("FAIL req_accept_timeout: addr 0x%08h never accepted", a);
         req_valid = 1'b0;
         return;
      end
      @(posedge CLK); #1;
      req_valid = 1'b0;
      if (stall_n > 0) mem_stall = 1'b1;
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         @(posedge CLK); #1;
         lat++;
         if (stall_n > 0 && lat > stall_n) mem_stall = 1'b0;
      end
      if (!rsp_valid) begin
         n_checks++; n_fail++;
         $display("FAIL rsp_timeout: addr 0x%08h got no response", a);
         return;
      end
      rd = rsp_rdata; err = rsp_err;
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      int          w, l, n0, r0, w0;

      #1;
      chk("reset_ready", {31'b0, req_ready}, 0);
      chk("reset_rsp", {31'b0, rsp_valid}, 0);
      chk("reset_wr_en", {31'b0, mem_wr_en}, 0);
      repeat (3) @(posedge CLK);
      #1 Reset = 1'b1;

      do_req(1, T_W, 32'h100, 32'hDEADBEEF, 0, rd, err, w, l);
      chk("sw_lat", l, 1); chk("sw_err", {31'b0, err}, 0); chk("sw_rdata", rd, 0);
      do_req(0, T_W, 32'h100, 0, 0, rd, err, w, l);
      chk("lw_rdata", rd, 32'hDEADBEEF); chk("lw_lat", l, 2); chk("lw_err", {31'b0, err}, 0);

      do_req(1, T_B, 32'h103, 32'h80, 0, rd, err, w, l);
      do_req(1, T_B, 32'h102, 32'h01, 0, rd, err, w, l);
      do_req(0, T_B, 32'h103, 0, 0, rd, err, w, l);
      chk("lb_sign", rd, 32'hFFFFFF80);
      do_req(0, T_BU, 32'h103, 0, 0, rd, err, w, l);
      chk("lbu_zero", rd, 32'h00000080);
      do_req(0, T_H, 32'h102, 0, 2, rd, err, w, l);
      chk("lh_sign", rd, 32'hFFFF8001); chk("lh_stall_lat", l, 4);
      do_req(0, T_HU, 32'h102, 0, 0, rd, err, w, l);
      chk("lhu_zero", rd, 32'h00008001);

      r0 = n_rd; w0 = n_wr;
      do_req(1, T_H, 32'h101, 32'h55, 0, rd, err, w, l);
      chk("sh_mis_err", {31'b0, err}, 1); chk("sh_mis_rdata", rd, 0);
      do_req(1, T_W, 32'h102, 32'h66, 0, rd, err, w, l);
      chk("sw_mis_err", {31'b0, err}, 1);
      do_req(0, T_BAD, 32'h100, 0, 0, rd, err, w, l);
      chk("type011_err", {31'b0, err}, 1);
      do_req(1, T_BU, 32'h100, 32'h77, 0, rd, err, w, l);
      chk("sbu_err", {31'b0, err}, 1);
      chk("err_no_rd", n_rd, r0); chk("err_no_wr", n_wr, w0);

      mem_stall = 1'b1;
      do_req(1, T_W, 32'h10, 32'h1, 0, rd, err, w, l);
      do_req(1, T_W, 32'h14, 32'h2, 0, rd, err, w, l);
      @(posedge CLK); #1;
      req_valid = 1'b1; req_we = 1'b1; req_type = T_W; req_addr = 32'h18; req_wdata = 32'h3;
      #1 chk("full_ready", {31'b0, req_ready}, 0);
      repeat (2) @(posedge CLK);
      #2 chk("full_ready_hold", {31'b0, req_ready}, 0);
      n0 = cm_addr.size();
      mem_stall = 1'b0;
      do_req(1, T_W, 32'h18, 32'h3, 0, rd, err, w, l);
      @(posedge CLK); #1;
      if (cm_addr.size() < n0 + 2) begin
         n_checks++; n_fail++;
         $display("FAIL drain_count: got %0d commits expected %0d", cm_addr.size() - n0, 2);
      end else begin
         chk("drain_first", cm_addr[n0], 32'h10);
         chk("drain_second", cm_addr[n0+1], 32'h14);
         chk("drain_back_to_back", cm_cyc[n0+1] - cm_cyc[n0], 1);
      end

      do_req(1, T_W, 32'h200, 32'h12345678, 0, rd, err, w, l);
      do_req(0, T_W, 32'h200, 0, 0, rd, err, w, l);
      chk("raw_rdata", rd, 32'h12345678);

      mem_stall = 1'b1;
      do_req(1, T_W, 32'h300, 32'h5, 0, rd, err, w, l);
      do_req(1, T_W, 32'h304, 32'h6, 0, rd, err, w, l);
      @(posedge CLK); #1;
      chk("pre_reset_wr_en", {31'b0, mem_wr_en}, 1);
      n0 = cm_addr.size();
      Reset = 1'b0;
      #1;
      chk("async_wr_en", {31'b0, mem_wr_en}, 0);
      chk("async_addr", mem_addr, 0);
      chk("async_wdata", mem_wdata, 0);
      chk("async_ready", {31'b0, req_ready}, 0);
      repeat (2) @(posedge CLK);
      #1 Reset = 1'b1; mem_stall = 1'b0;
      do_req(0, T_W, 32'h200, 0, 0, rd, err, w, l);
      chk("post_reset_wait", w, 0);
      chk("post_reset_rdata", rd, 32'h12345678);
      chk("post_reset_lat", l, 2);
      chk("discarded_stores", cm_addr.size(), n0);

      repeat (3) @(posedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
